// File: rtl/imem_dmem_arbiter.sv
// Single-port memory arbiter for fetch (read-only) and the load/store unit.
// One transaction in flight; LSU has priority, with a starvation override for fetch.
module imem_dmem_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 3,
  parameter int CNT_W      = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                if_req_i,
  input  logic [XLEN-1:0]     if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [XLEN-1:0]     if_rdata_o,
  input  logic                ls_req_i,
  input  logic                ls_we_i,
  input  logic [XLEN-1:0]     ls_addr_i,
  input  logic [XLEN-1:0]     ls_wdata_i,
  input  logic [XLEN/8-1:0]   ls_be_i,
  output logic                ls_gnt_o,
  output logic                ls_rvalid_o,
  output logic [XLEN-1:0]     ls_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [XLEN-1:0]     mem_addr_o,
  output logic [XLEN-1:0]     mem_wdata_o,
  output logic [XLEN/8-1:0]   mem_be_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [XLEN-1:0]     mem_rdata_i,
  output logic [CNT_W-1:0]    if_stall_cnt_o,
  output logic [1:0]          dbg_state_o
);

  // Handshake: *_req is held until its *_gnt pulse; mem_req_o is held until
  // mem_gnt_i; every *_rvalid is a single-cycle pulse carrying its data.

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam int BW = XLEN / 8;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_LS = 2'd2} owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q;
  logic [SW-1:0]     starve_q;
  logic [CNT_W-1:0]  stall_q;
  logic              we_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [BW-1:0]     be_q;
  logic              if_win;
  logic              ls_win;
  logic              resp;

  always_comb begin
    state_d = state_q;
    if_win  = 1'b0;
    ls_win  = 1'b0;
    case (state_q)
      IDLE: begin
        // LSU wins unless fetch has already lost STARVE_MAX times in a row
        if (ls_req_i && !(if_req_i && starve_q == STARVE_TOP)) ls_win = 1'b1;
        else if (if_req_i) if_win = 1'b1;
        if (if_win || ls_win) state_d = REQ;
      end
      REQ:     if (mem_gnt_i) state_d = WAIT;
      WAIT:    if (mem_rvalid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    resp        = (state_q == WAIT) && mem_rvalid_i && !rst_i;
    if_gnt_o    = if_win && !rst_i;
    ls_gnt_o    = ls_win && !rst_i;
    if_rvalid_o = resp && (owner_q == OWN_IF);
    ls_rvalid_o = resp && (owner_q == OWN_LS);
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    ls_rdata_o  = ls_rvalid_o ? mem_rdata_i : '0;
    mem_req_o   = (state_q == REQ);
    mem_we_o    = mem_req_o ? we_q : 1'b0;
    mem_addr_o  = mem_req_o ? addr_q : '0;
    mem_wdata_o = mem_req_o ? wdata_q : '0;
    mem_be_o    = mem_req_o ? be_q : '0;
    if_stall_cnt_o = stall_q;
    dbg_state_o    = state_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_q  <= OWN_NONE;
      starve_q <= '0;
      stall_q  <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
    end else begin
      state_q <= state_d;
      if (if_win) begin
        owner_q <= OWN_IF;
        we_q    <= 1'b0;
        addr_q  <= if_addr_i;
        wdata_q <= '0;
        be_q    <= '1;
      end else if (ls_win) begin
        owner_q <= OWN_LS;
        we_q    <= ls_we_i;
        addr_q  <= ls_addr_i;
        wdata_q <= ls_wdata_i;
        be_q    <= ls_be_i;
      end else if (state_q == WAIT && mem_rvalid_i) begin
        owner_q <= OWN_NONE;
      end
      if (if_win) starve_q <= '0;
      else if (ls_win && if_req_i && starve_q < STARVE_TOP) starve_q <= starve_q + 1'b1;
      if (if_req_i && !if_win) stall_q <= stall_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Testbench for imem_dmem_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_imem_dmem_arbiter;
  localparam int XLEN = 32;
  localparam int SMAX = 3;
  localparam int CNT_W = 32;

  logic clk, rst;
  logic if_req, ls_req, ls_we, mem_gnt, mem_rvalid;
  logic [XLEN-1:0] if_addr, ls_addr, ls_wdata, mem_rdata;
  logic [3:0] ls_be;
  logic if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_we;
  logic [XLEN-1:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_be;
  logic [CNT_W-1:0] stall_cnt;
  logic [1:0] dbg_state;

  int total = 0;
  int bad = 0;
  logic [XLEN-1:0] exp_q[$];

  imem_dmem_arbiter #(.XLEN(XLEN), .STARVE_MAX(SMAX), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
    .ls_be_i(ls_be), .ls_gnt_o(ls_gnt), .ls_rvalid_o(ls_rvalid), .ls_rdata_o(ls_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .if_stall_cnt_o(stall_cnt), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0; ls_be = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    adv();
    adv();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    total++; if ({if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_req, mem_we} !== 6'b0) begin bad++; $display("FAIL reset_ctrl got=%b exp=000000", {if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_req, mem_we}); end
    total++; if ({if_rdata, ls_rdata, mem_addr, mem_wdata, mem_be} !== '0) begin bad++; $display("FAIL reset_data got nonzero exp=0"); end
    total++; if (stall_cnt !== 0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    adv();
  endtask

  task automatic test_fetch_only();
    do_reset();
    if_req = 1; if_addr = 32'h8000_0000;
    settle();
    total++; if (if_gnt !== 1'b1 || ls_gnt !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL t1_c0 got if_gnt=%b ls_gnt=%b mem_req=%b exp=1,0,0", if_gnt, ls_gnt, mem_req); end
    adv(); if_req = 0; mem_gnt = 1;
    settle();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0000) begin bad++; $display("FAIL t1_c1_req got req=%b addr=%h exp=1,80000000", mem_req, mem_addr); end
    total++; if (mem_be !== 4'hF || mem_we !== 1'b0) begin bad++; $display("FAIL t1_c1_be got be=%h we=%b exp=f,0", mem_be, mem_we); end
    adv(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0013;
    settle();
    total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h13 || ls_rvalid !== 1'b0) begin bad++; $display("FAIL t1_c2_resp got rv=%b rdata=%h ls_rv=%b exp=1,13,0", if_rvalid, if_rdata, ls_rvalid); end
    adv(); mem_rvalid = 0;
    settle();
    total++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h0) begin bad++; $display("FAIL t1_c3_idle got rv=%b rdata=%h exp=0,0", if_rvalid, if_rdata); end
    adv();
  endtask

  task automatic test_both_request();
    do_reset();
    if_req = 1; if_addr = 32'h8000_0040;
    ls_req = 1; ls_we = 1; ls_addr = 32'h8000_1000; ls_wdata = 32'hDEAD_BEEF; ls_be = 4'h3;
    settle();
    total++; if (ls_gnt !== 1'b1 || if_gnt !== 1'b0) begin bad++; $display("FAIL t2_gnt got ls=%b if=%b exp=1,0", ls_gnt, if_gnt); end
    adv(); ls_req = 0; mem_gnt = 1;
    settle();
    total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'h3 || mem_addr !== 32'h8000_1000 || mem_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL t2_mem got req=%b we=%b be=%h addr=%h wdata=%h exp=1,1,3,80001000,deadbeef", mem_req, mem_we, mem_be, mem_addr, mem_wdata); end
    total++; if (if_gnt !== 1'b0) begin bad++; $display("FAIL t2_no_if_gnt_busy got=%b exp=0", if_gnt); end
    adv(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0;
    settle();
    total++; if (ls_rvalid !== 1'b1 || if_rvalid !== 1'b0) begin bad++; $display("FAIL t2_ack got ls_rv=%b if_rv=%b exp=1,0", ls_rvalid, if_rvalid); end
    adv(); mem_rvalid = 0;
    settle();
    total++; if (if_gnt !== 1'b1 || ls_gnt !== 1'b0) begin bad++; $display("FAIL t2_if_next got if=%b ls=%b exp=1,0", if_gnt, ls_gnt); end
    total++; if (stall_cnt !== 32'd3) begin bad++; $display("FAIL t2_stall got=%0d exp=3", stall_cnt); end
    adv(); if_req = 0;
  endtask

  task automatic test_starvation();
    int losses;
    logic e_if, e_ls;
    do_reset();
    if_req = 1; if_addr = 32'h0000_0100;
    ls_req = 1; ls_we = 0; ls_addr = 32'h0000_2000; ls_be = 4'hF;
    mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    losses = 0;
    for (int k = 0; k < 24; k++) begin
      e_if = 0; e_ls = 0;
      if (k % 3 == 0) begin
        e_if = (losses == SMAX);
        e_ls = !e_if;
        losses = e_if ? 0 : ((losses + 1 > SMAX) ? SMAX : losses + 1);
      end
      settle();
      total++; if (if_gnt !== e_if || ls_gnt !== e_ls) begin bad++; $display("FAIL t3_arb k=%0d got if=%b ls=%b exp if=%b ls=%b", k, if_gnt, ls_gnt, e_if, e_ls); end
      adv();
    end
    if_req = 0; ls_req = 0; mem_gnt = 0; mem_rvalid = 0;
  endtask

  task automatic test_backpressure();
    do_reset();
    ls_req = 1; ls_we = 1; ls_addr = 32'h0000_3000; ls_wdata = 32'hCAFE_F00D; ls_be = 4'hC;
    settle();
    total++; if (ls_gnt !== 1'b1) begin bad++; $display("FAIL t4_gnt got=%b exp=1", ls_gnt); end
    adv(); ls_req = 0; if_req = 1; if_addr = 32'h0000_0200;
    for (int k = 0; k < 5; k++) begin
      settle();
      total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_3000 || mem_wdata !== 32'hCAFE_F00D || mem_be !== 4'hC) begin bad++; $display("FAIL t4_hold k=%0d got req=%b addr=%h wdata=%h be=%h", k, mem_req, mem_addr, mem_wdata, mem_be); end
      total++; if (if_gnt !== 1'b0 || ls_gnt !== 1'b0) begin bad++; $display("FAIL t4_nogrant k=%0d got if=%b ls=%b exp=0,0", k, if_gnt, ls_gnt); end
      adv();
    end
    mem_gnt = 1;
    adv(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0;
    adv(); mem_rvalid = 0;
    settle();
    total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL t4_if_gnt got=%b exp=1", if_gnt); end
    total++; if (stall_cnt !== 32'd7) begin bad++; $display("FAIL t4_stall got=%0d exp=7", stall_cnt); end
    adv(); if_req = 0;
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    ls_req = 1; ls_we = 0; ls_addr = 32'h0000_4000; ls_be = 4'hF;
    adv(); ls_req = 0; mem_gnt = 1;
    adv(); mem_gnt = 0;
    settle();
    total++; if (mem_req !== 1'b0 || ls_rvalid !== 1'b0) begin bad++; $display("FAIL t5_wait got req=%b rv=%b exp=0,0", mem_req, ls_rvalid); end
    adv(); rst = 1;
    adv(); rst = 0; mem_rvalid = 1; mem_rdata = 32'hA5A5_A5A5;
    settle();
    total++; if (ls_rvalid !== 1'b0 || if_rvalid !== 1'b0 || ls_rdata !== 32'h0) begin bad++; $display("FAIL t5_stray got ls_rv=%b if_rv=%b rdata=%h exp=0,0,0", ls_rvalid, if_rvalid, ls_rdata); end
    total++; if (dbg_state !== 2'd0 || mem_req !== 1'b0 || stall_cnt !== 0) begin bad++; $display("FAIL t5_state got st=%0d req=%b stall=%0d exp=0,0,0", dbg_state, mem_req, stall_cnt); end
    adv(); mem_rvalid = 0;
  endtask

  task automatic test_stray_rvalid();
    do_reset();
    mem_rvalid = 1; mem_rdata = $urandom;
    settle();
    total++; if (if_rvalid !== 1'b0 || ls_rvalid !== 1'b0 || if_rdata !== 0 || ls_rdata !== 0) begin bad++; $display("FAIL t6_idle got if_rv=%b ls_rv=%b exp=0,0", if_rvalid, ls_rvalid); end
    adv(); if_req = 1; if_addr = 32'h0000_0500;
    settle();
    total++; if (if_gnt !== 1'b1 || if_rvalid !== 1'b0) begin bad++; $display("FAIL t6_arb got gnt=%b rv=%b exp=1,0", if_gnt, if_rvalid); end
    adv(); if_req = 0;
    settle();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0500) begin bad++; $display("FAIL t6_req got req=%b addr=%h exp=1,00000500", mem_req, mem_addr); end
    adv(); mem_rvalid = 0;
  endtask

  // Randomized run: the model tracks one outstanding transaction as a record
  // and applies the priority/starvation rules with plain counters.
  task automatic test_random();
    bit if_pend, ls_pend, busy, accepted;
    int owner, losses;
    logic e_we;
    logic [XLEN-1:0] e_wdata;
    logic [3:0] e_be;
    logic [CNT_W-1:0] stall;
    logic e_if_gnt, e_ls_gnt, e_mem_req, e_if_rv, e_ls_rv;
    do_reset();
    exp_q.delete();
    if_pend = 0; ls_pend = 0; busy = 0; accepted = 0; owner = 0; losses = 0; stall = 0;
    e_we = 0; e_wdata = 0; e_be = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1; if_addr = $urandom & 32'hFFFF_FFFE;
      end
      if (!ls_pend && $urandom_range(0, 2) == 0) begin
        ls_pend = 1; ls_we = 1'($urandom_range(0, 1)); ls_addr = $urandom;
        ls_wdata = $urandom; ls_be = 4'($urandom_range(0, 15));
      end
      if_req = if_pend; ls_req = ls_pend;
      mem_gnt = 1'($urandom_range(0, 1));
      mem_rvalid = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      e_if_gnt = 0; e_ls_gnt = 0;
      if (!busy) begin
        if (ls_req && !(if_req && losses == SMAX)) e_ls_gnt = 1;
        else if (if_req) e_if_gnt = 1;
      end
      e_mem_req = busy && !accepted;
      e_if_rv = busy && accepted && mem_rvalid && owner == 1;
      e_ls_rv = busy && accepted && mem_rvalid && owner == 2;
      settle();
      total++; if (if_gnt !== e_if_gnt || ls_gnt !== e_ls_gnt) begin bad++; $display("FAIL rnd_gnt cyc=%0d got if=%b ls=%b exp if=%b ls=%b", cyc, if_gnt, ls_gnt, e_if_gnt, e_ls_gnt); end
      total++; if (mem_req !== e_mem_req) begin bad++; $display("FAIL rnd_mem_req cyc=%0d got=%b exp=%b", cyc, mem_req, e_mem_req); end
      if (e_mem_req && exp_q.size() > 0) begin
        total++; if (mem_addr !== exp_q[0] || mem_we !== e_we || mem_wdata !== e_wdata || mem_be !== e_be) begin bad++; $display("FAIL rnd_mem_fields cyc=%0d got addr=%h we=%b wd=%h be=%h exp addr=%h we=%b wd=%h be=%h", cyc, mem_addr, mem_we, mem_wdata, mem_be, exp_q[0], e_we, e_wdata, e_be); end
      end
      total++; if (if_rvalid !== e_if_rv || if_rdata !== (e_if_rv ? mem_rdata : 32'h0)) begin bad++; $display("FAIL rnd_if_resp cyc=%0d got rv=%b rd=%h exp rv=%b", cyc, if_rvalid, if_rdata, e_if_rv); end
      total++; if (ls_rvalid !== e_ls_rv || ls_rdata !== (e_ls_rv ? mem_rdata : 32'h0)) begin bad++; $display("FAIL rnd_ls_resp cyc=%0d got rv=%b rd=%h exp rv=%b", cyc, ls_rvalid, ls_rdata, e_ls_rv); end
      total++; if (stall_cnt !== stall) begin bad++; $display("FAIL rnd_stall cyc=%0d got=%0d exp=%0d", cyc, stall_cnt, stall); end
      if (busy && !accepted && mem_gnt) begin
        accepted = 1;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else if (busy && accepted && mem_rvalid) begin
        busy = 0;
      end else if (e_if_gnt || e_ls_gnt) begin
        busy = 1; accepted = 0;
        owner = e_if_gnt ? 1 : 2;
        exp_q.push_back(e_if_gnt ? if_addr : ls_addr);
        e_we = e_if_gnt ? 1'b0 : ls_we;
        e_wdata = e_if_gnt ? 32'h0 : ls_wdata;
        e_be = e_if_gnt ? 4'hF : ls_be;
      end
      if (e_if_gnt) losses = 0;
      else if (e_ls_gnt && if_req && losses < SMAX) losses++;
      if (if_req && !e_if_gnt) stall = stall + 1;
      if (e_if_gnt) if_pend = 0;
      if (e_ls_gnt) ls_pend = 0;
      adv();
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_fetch_only();
    test_both_request();
    test_starvation();
    test_backpressure();
    test_reset_in_wait();
    test_stray_rvalid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
